uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and UART handshake bundle for the 4-way TX arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_rdy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;

    // master = requesters plus UART side, slave = the arbiter
    modport master (
        output req_valid, req_data, req_last, tx_rdy,
        input  req_ready, tx_en, tx_data, grant_id, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_rdy,
        output req_ready, tx_en, tx_data, grant_id, busy, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter feeding four byte sources
//            into one UART transmitter, with a transmit-start timeout.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  wire logic        clk_50m,
    input  wire logic        rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [9:0] c_TIMEOUT = 10'(TIMEOUT);

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [1:0] r_last_grant;
    logic [1:0] r_lock_id;
    logic       r_locked;
    logic       r_armed;
    logic       r_tx_en;
    logic [7:0] r_tx_data;
    logic [1:0] r_grant_id;
    logic [3:0] r_req_ready;
    logic       r_busy;
    logic       r_err;

    logic [3:0] w_eligible;
    logic [3:0] w_cand;
    logic [1:0] w_winner;
    logic       w_accept;
    logic [7:0] w_byte;

    // Descending scan so the candidate nearest after last_grant is written last.
    always_comb begin
        w_eligible = r_locked ? (4'b0001 << r_lock_id) : 4'b1111;
        w_cand     = bus.req_valid & w_eligible;
        w_winner   = r_last_grant;
        for (int i = 4; i >= 1; i--) begin
            if (w_cand[r_last_grant + 2'(i)]) begin
                w_winner = r_last_grant + 2'(i);
            end
        end
        w_accept = (r_state == S_IDLE) && r_armed && bus.tx_rdy && (|w_cand);
        w_byte   = bus.req_data[{w_winner, 3'b000} +: 8];
    end

    // r_armed holds off acceptance until the second edge after reset release.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 2'd3;
            r_lock_id    <= 2'd0;
            r_locked     <= 1'b0;
            r_armed      <= 1'b0;
            r_tx_en      <= 1'b0;
            r_tx_data    <= 8'h00;
            r_grant_id   <= 2'd0;
            r_req_ready  <= 4'b0000;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_req_ready <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_SEND;
                        r_busy       <= 1'b1;
                        r_tx_en      <= 1'b1;
                        r_tx_data    <= w_byte;
                        r_grant_id   <= w_winner;
                        r_req_ready  <= 4'b0001 << w_winner;
                        r_last_grant <= w_winner;
                        r_locked     <= ~bus.req_last[w_winner];
                        r_lock_id    <= w_winner;
                        r_cnt        <= '0;
                    end
                end
                S_SEND: begin
                    // r_cnt + 1 is the number of SEND cycles elapsed at this edge
                    r_cnt <= r_cnt + 10'd1;
                    if (!bus.tx_rdy) begin
                        r_state <= S_DRAIN;
                        r_tx_en <= 1'b0;
                    end else if (r_cnt + 10'd1 == c_TIMEOUT) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_tx_en  <= 1'b0;
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (bus.tx_rdy) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.tx_en       = r_tx_en;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Randomised bench for uart_tx_arbiter against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int TO = 40;
    localparam int PH_IDLE  = 0;
    localparam int PH_STROBE = 1;
    localparam int PH_DRAIN = 2;

    logic clk_50m;
    logic rst;
    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT(TO)) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    int n_total = 0;
    int n_bad   = 0;

    // Requester byte queues
    logic [7:0] q_data [4][$];
    bit         q_last [4][$];
    bit [3:0]   gate;
    bit         rand_gate, rand_to, rand_idle_low;

    // Reference: who owns the UART, whose turn it is, who holds a packet
    int         m_phase, m_age, m_last, m_lock, m_win;
    bit         m_armed, m_txen, m_err;
    logic [7:0] m_data;
    logic [1:0] m_gid;
    logic [3:0] m_ready;

    // UART behaviour
    bit u_rdy, u_nodrop;
    int u_wait, u_low, u_fix;

    int         dut_log [$];
    logic [7:0] data_log [$];
    int         run_log [$];
    int         run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int log_at(input int k);
        return (k < dut_log.size()) ? dut_log[k] : 99;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_age = 0; m_last = 3; m_lock = -1; m_win = -1;
        m_armed = 1'b0; m_txen = 1'b0; m_err = 1'b0;
        m_data = 8'h00; m_gid = 2'd0; m_ready = 4'b0000;
    endtask

    // One clock edge, applied to the inputs that were presented during the last cycle
    task automatic model_edge();
        int c;
        m_ready = 4'b0000;
        m_win   = -1;
        if (m_phase == PH_IDLE) begin
            if (m_armed && bus.tx_rdy) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (m_win < 0 && bus.req_valid[c] && (m_lock < 0 || m_lock == c)) m_win = c;
                end
                if (m_win >= 0) begin
                    m_ready[m_win] = 1'b1;
                    m_txen  = 1'b1;
                    m_data  = bus.req_data[m_win*8 +: 8];
                    m_gid   = 2'(m_win);
                    m_last  = m_win;
                    m_lock  = bus.req_last[m_win] ? -1 : m_win;
                    m_phase = PH_STROBE;
                    m_age   = 0;
                end
            end
        end else if (m_phase == PH_STROBE) begin
            m_age++;
            if (!bus.tx_rdy) begin
                m_txen = 1'b0; m_phase = PH_DRAIN;
            end else if (m_age == TO) begin
                m_txen = 1'b0; m_err = 1'b1; m_lock = -1; m_phase = PH_IDLE;
            end
        end else begin
            if (bus.tx_rdy) m_phase = PH_IDLE;
        end
        m_armed = 1'b1;
    endtask

    task automatic drive();
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        for (int i = 0; i < 4; i++) begin
            if (rand_gate) gate[i] = ($urandom % 4) != 0;
            if (q_data[i].size() > 0 && gate[i]) begin
                v[i] = 1'b1; d[i*8 +: 8] = q_data[i][0]; l[i] = q_last[i][0];
            end else begin
                v[i] = 1'b0; d[i*8 +: 8] = 8'($urandom); l[i] = 1'($urandom);
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.tx_rdy    = u_rdy;
    endtask

    task automatic step();
        @(negedge clk_50m);
        model_edge();
        check("req_ready", bus.req_ready, m_ready);
        check("tx_en", bus.tx_en, m_txen);
        check("busy", bus.busy, m_phase != PH_IDLE);
        check("grant_id", bus.grant_id, m_gid);
        check("tx_data", bus.tx_data, m_data);
        check("err_timeout", bus.err_timeout, m_err);
        if (bus.req_ready != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (bus.req_ready[i]) dut_log.push_back(i);
            data_log.push_back(bus.tx_data);
        end
        if (bus.tx_en) run++;
        else if (run > 0) begin run_log.push_back(run); run = 0; end
        if (m_win >= 0) begin
            void'(q_data[m_win].pop_front());
            void'(q_last[m_win].pop_front());
        end
        if (u_low > 0) begin
            u_low--;
            if (u_low == 0) u_rdy = 1'b1;
        end else if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) begin u_rdy = 1'b0; u_low = $urandom_range(1, 4); end
        end else if (m_phase == PH_IDLE && rand_idle_low && ($urandom % 8) == 0) begin
            u_rdy = 1'b0; u_low = 1;
        end
        if (m_win >= 0)
            u_wait = (u_nodrop || (rand_to && ($urandom % 16) == 0)) ? 0 :
                     (u_fix > 0 ? u_fix : $urandom_range(1, 3));
        drive();
    endtask

    task automatic do_reset();
        #5 rst = 1'b1;
        #1;
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_err", bus.err_timeout, 0);
        model_reset();
        u_rdy = 1'b1; u_wait = 0; u_low = 0; run = 0;
        drive();
        @(negedge clk_50m);
        @(negedge clk_50m);
        #2 rst = 1'b0;
    endtask

    task automatic push(input int i, input logic [7:0] b, input bit last);
        q_data[i].push_back(b);
        q_last[i].push_back(last);
    endtask

    task automatic run_until_idle(input int max);
        bit idle;
        int k;
        idle = 1'b0;
        k = 0;
        while (!idle && k < max) begin
            step();
            k++;
            idle = (m_phase == PH_IDLE) && (q_data[0].size() + q_data[1].size() +
                    q_data[2].size() + q_data[3].size() == 0);
        end
        check("drain_bound", idle, 1);
    endtask

    task automatic wait_acc(input int n, input int max);
        int k;
        k = 0;
        while (dut_log.size() < n && k < max) begin step(); k++; end
        if (dut_log.size() < n) check("wait_acc", dut_log.size(), n);
    endtask

    initial begin
        rst = 1'b0;
        gate = 4'b1111;
        rand_gate = 0; rand_to = 0; rand_idle_low = 0;
        u_nodrop = 0; u_fix = 0;
        do_reset();

        // Single byte from requester 2
        u_fix = 2;
        push(2, 8'h48, 1'b1);
        run_until_idle(200);
        check("single_count", dut_log.size(), 1);
        check("single_grant", log_at(0), 2);
        check("single_data", (data_log.size() > 0) ? data_log[0] : 8'hxx, 8'h48);
        u_fix = 0;

        // Round robin from reset
        do_reset();
        dut_log.delete();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) push(i, 8'($urandom), 1'b1);
        run_until_idle(500);
        for (int k = 0; k < 5; k++) check($sformatf("rr_%0d", k), log_at(k), k % 4);

        // Packet lock: requester 1 keeps the grant for three bytes
        dut_log.delete();
        push(0, 8'h10, 1'b1);
        run_until_idle(100);
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
        push(0, 8'h11, 1'b1);
        run_until_idle(300);
        check("lock_0", log_at(1), 1);
        check("lock_1", log_at(2), 1);
        check("lock_2", log_at(3), 1);
        check("lock_3", log_at(4), 0);

        // Lock stall: locked requester goes quiet while another waits
        dut_log.delete();
        push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1); push(0, 8'hB0, 1'b1);
        wait_acc(1, 50);
        gate[1] = 1'b0;
        repeat (50) step();
        check("stall_count", dut_log.size(), 1);
        check("stall_busy", bus.busy, 0);
        gate[1] = 1'b1;
        run_until_idle(200);
        check("stall_order1", log_at(1), 1);
        check("stall_order2", log_at(2), 0);

        // Timeout on a locking byte, then the next requester proceeds
        dut_log.delete(); run_log.delete();
        u_nodrop = 1;
        push(2, 8'hC2, 1'b0); push(3, 8'hC3, 1'b1);
        wait_acc(1, 50);
        u_nodrop = 0;
        run_until_idle(TO * 3 + 100);
        check("to_run", (run_log.size() > 0) ? run_log[0] : -1, TO);
        check("to_err_sticky", bus.err_timeout, 1);
        check("to_first", log_at(0), 2);
        check("to_next", log_at(1), 3);

        // Reset in the middle of a strobe
        dut_log.delete();
        u_nodrop = 1;
        push(1, 8'hD1, 1'b1);
        wait_acc(1, 50);
        repeat (3) step();
        check("pre_rst_tx_en", bus.tx_en, 1);
        do_reset();
        u_nodrop = 0;
        dut_log.delete();
        push(3, 8'hD3, 1'b1); push(0, 8'hD0, 1'b1);
        run_until_idle(200);
        check("post_rst_first", log_at(0), 0);
        check("post_rst_second", log_at(1), 3);

        // Random traffic
        rand_gate = 1; rand_to = 1; rand_idle_low = 1;
        for (int n = 0; n < 2000; n++) begin
            if (($urandom % 5) == 0) begin
                int i, len;
                i = $urandom_range(0, 3);
                len = $urandom_range(1, 3);
                if (q_data[i].size() < 4)
                    for (int j = 0; j < len; j++) push(i, 8'($urandom), j == len - 1);
            end
            step();
        end
        rand_gate = 0; rand_to = 0; rand_idle_low = 0;
        gate = 4'b1111;
        run_until_idle(TO * 20 + 1000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
